// File: rtl/ft232h_pkg.sv
// Shared definitions for the FT232H synchronous-FIFO memory master and its device model.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
// Contents: FSM state codes, word size, pin idle levels, address alignment helper.
package ft232h_pkg;

  localparam int FT_WORD_BYTES = 8;

  // FSM state codes
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_TURN     = 3'd2;
  localparam logic [2:0] ST_WAIT_RXF = 3'd3;
  localparam logic [2:0] ST_OE       = 3'd4;
  localparam logic [2:0] ST_READ     = 3'd5;
  localparam logic [2:0] ST_RESP     = 3'd6;

  // Active-low strobes towards the FT232H, kept together so idling them is one assignment.
  typedef struct packed {
    logic wr_n;
    logic rd_n;
    logic oe_n;
  } pins_t;

  localparam pins_t PINS_IDLE   = '{wr_n: 1'b1, rd_n: 1'b1, oe_n: 1'b1};
  localparam logic  SIWU_N_IDLE = 1'b1;

  // Requests are whole 64-bit words; the low three address bits are forced to zero.
  function automatic logic [63:0] align_addr(input logic [63:0] a);
    return {a[63:3], 3'b000};
  endfunction

endpackage

// File: rtl/ft232h_timeout.sv
// Stall watchdog: counts stalled cycles, cleared by progress, flags expiry on the LIMIT-th stall.
// Latency: expired is combinational from inc and the registered count (same cycle).
// Backpressure: none; the owner decides what to abort.
// Ports: clk, rst (async high), clr (restart count), inc (one stalled cycle), expired (out).
module ft232h_timeout #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Fires on the stalled cycle that would bring the count to LIMIT.
  assign expired = inc && !clr && (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ft232h_mem_master.sv
// FT232H sync-FIFO read initiator: sends an 8-byte aligned address, turns the bus, reads 8 data bytes.
// Latency: request accept to rsp_valid is 8 + TURN_CYCLES + 1 + 1 + 8 + 1 cycles when unstalled.
// Backpressure: req_ready only in IDLE; txe_n/rxf_n stall the byte phases; rsp has no backpressure.
// Ports: clk/rst; req_valid/req_ready/req_addr in; rsp_valid/rsp_data/rsp_err out;
//        adbus (inout), txe_n/rxf_n from the FT232H; wr_n/rd_n/oe_n/siwu_n to the FT232H.
module ft232h_mem_master
  import ft232h_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TURN_CYCLES    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  output logic        rsp_valid,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  inout  wire  [7:0]  adbus,
  input  logic        txe_n,
  output logic        wr_n,
  output logic        siwu_n,
  input  logic        rxf_n,
  output logic        oe_n,
  output logic        rd_n
);

  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

  logic [2:0]    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [63:0]   shift_q, shift_d;
  logic [63:0]   data_q, data_d;
  logic [TW-1:0] turn_q, turn_d;
  pins_t         pins_q, pins_d;
  logic          drive_q, drive_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [63:0]   rsp_data_q, rsp_data_d;

  logic byte_wr, byte_rd, turn_last;
  logic to_clr, to_inc, to_expired;

  // A byte moves only on an edge where both our strobe and the device's flag are low.
  assign byte_wr   = (state_q == ST_ADDR) && !pins_q.wr_n && !txe_n;
  assign byte_rd   = (state_q == ST_READ) && !pins_q.rd_n && !rxf_n;
  assign turn_last = (turn_q == TW'(TURN_CYCLES - 1));

  // Watchdog restarts on every byte of progress and when the read wait begins.
  assign to_clr = (state_q == ST_IDLE) || byte_wr || byte_rd ||
                  ((state_q == ST_TURN) && turn_last);
  assign to_inc = ((state_q == ST_ADDR) && txe_n) ||
                  (((state_q == ST_WAIT_RXF) || (state_q == ST_READ)) && rxf_n);

  ft232h_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (to_clr),
    .inc     (to_inc),
    .expired (to_expired)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    turn_d      = turn_q;
    pins_d      = pins_q;
    drive_d     = drive_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          shift_d     = align_addr(req_addr);
          cnt_d       = '0;
          drive_d     = 1'b1;
          pins_d.wr_n = txe_n;
          state_d     = ST_ADDR;
        end
      end
      ST_ADDR: begin
        // wr_n tracks txe_n so a full device sees the strobe drop while the byte is held.
        pins_d.wr_n = txe_n;
        if (byte_wr) begin
          shift_d = shift_q >> 8;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            pins_d.wr_n = 1'b1;
            drive_d     = 1'b0;
            turn_d      = '0;
            state_d     = ST_TURN;
          end
        end
      end
      ST_TURN: begin
        if (turn_last) begin
          state_d = ST_WAIT_RXF;
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end
      ST_WAIT_RXF: begin
        if (!rxf_n) begin
          pins_d.oe_n = 1'b0;
          state_d     = ST_OE;
        end
      end
      ST_OE: begin
        // The device needs one cycle of oe_n low before rd_n may fall.
        pins_d.rd_n = 1'b0;
        cnt_d       = '0;
        state_d     = ST_READ;
      end
      ST_READ: begin
        if (byte_rd) begin
          data_d = {adbus, data_q[63:8]};
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            pins_d  = PINS_IDLE;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = data_q;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (to_expired) begin
      pins_d      = PINS_IDLE;
      drive_d     = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_data_d  = '0;
      state_d     = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      turn_q      <= '0;
      pins_q      <= PINS_IDLE;
      drive_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      turn_q      <= turn_d;
      pins_q      <= pins_d;
      drive_q     <= drive_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign adbus     = drive_q ? shift_q[7:0] : 8'bz;
  assign wr_n      = pins_q.wr_n;
  assign rd_n      = pins_q.rd_n;
  assign oe_n      = pins_q.oe_n;
  assign siwu_n    = SIWU_N_IDLE;
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_ft232h_mem_master.sv
// Bench for ft232h_mem_master: FT232H sync-FIFO device model, directed table, reset abort, random stalls.
module tb_ft232h_mem_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_err;
  wire  [7:0]  adbus;
  logic        txe_n;
  logic        wr_n;
  logic        siwu_n;
  wire         rxf_n;
  logic        oe_n;
  logic        rd_n;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // device model state
  logic        rxf_block;
  logic        dev_clr;
  logic [63:0] dev_addr;
  int          dev_addr_cnt;
  logic [63:0] dev_word;
  logic        dev_have;
  int          dev_rd_cnt;

  ft232h_mem_master #(.TIMEOUT_CYCLES(TO), .TURN_CYCLES(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .adbus     (adbus),
    .txe_n     (txe_n),
    .wr_n      (wr_n),
    .siwu_n    (siwu_n),
    .rxf_n     (rxf_n),
    .oe_n      (oe_n),
    .rd_n      (rd_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents seen by the host: one fixed word, a scrambled pattern elsewhere.
  function automatic logic [63:0] word_of(input logic [63:0] a);
    if (a == 64'h2000) return 64'h1122334455667788;
    return (a ^ 64'h5A5A0F0FC3C39696) * 64'd6364136223846793005;
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // FT232H device: drives adbus whenever oe_n is low, data ready after a full address.
  assign adbus = !oe_n ? dev_word[7:0] : 8'bz;
  assign rxf_n = rxf_block | ~dev_have;

  always @(posedge clk) begin
    if (rst || dev_clr) begin
      dev_addr     <= '0;
      dev_addr_cnt <= 0;
      dev_word     <= '0;
      dev_have     <= 1'b0;
      dev_rd_cnt   <= 0;
    end else begin
      if (!wr_n && !txe_n) begin
        dev_addr     <= {adbus, dev_addr[63:8]};
        dev_addr_cnt <= dev_addr_cnt + 1;
        if (dev_addr_cnt == 7) begin
          dev_word <= word_of({adbus, dev_addr[63:8]});
          dev_have <= 1'b1;
        end
      end
      if (!rd_n && !rxf_n && dev_have) begin
        dev_word   <= dev_word >> 8;
        dev_rd_cnt <= dev_rd_cnt + 1;
        if (dev_rd_cnt == 7) dev_have <= 1'b0;
      end
    end
  end

  // Pin protocol rules, every cycle.
  logic prev_rd_n = 1'b1, prev_oe_n = 1'b1;
  always @(negedge clk) begin
    if (!rst) begin
      check("wr_rd_both_low", {63'd0, (!wr_n && !rd_n)}, 64'd0);
      check("adbus_driven_oe_low", {63'd0, (dut.drive_q && !oe_n)}, 64'd0);
      if (prev_rd_n && !rd_n) check("oe_lead_rd", {63'd0, prev_oe_n}, 64'd0);
    end
    prev_rd_n = rd_n;
    prev_oe_n = oe_n;
  end

  // One read transaction with optional stalls; checks address bytes, response and latency.
  task automatic run_txn(input string nm, input logic [63:0] addr, input int stall_after,
                         input int stall_len, input bit rxf_never, input bit rnd,
                         input logic [63:0] exp_data, input bit exp_err, input int exp_lat);
    int acc = 0, lat = 0, t_left = 0, t_guard = 0, r_left = 0, r_guard = 0, n_hi = 0;
    bit got = 0, stalled = 0, mid_done = 0;
    logic [63:0] g_data = '0, sent;
    logic g_err = 1'b0;
    sent = addr & ~64'h7;
    @(negedge clk);
    check({nm, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    rxf_block = rxf_never;
    @(negedge clk);
    acc = cyc;
    req_valid = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      if (!rnd && stall_after >= 0 && !stalled && dev_addr_cnt == stall_after) begin
        stalled = 1;
        t_left  = stall_len;
      end
      if (rnd && t_left == 0 && t_guard == 0 && $urandom_range(3) == 0) t_left = $urandom_range(3, 1);
      if (t_left > 0) begin
        txe_n = 1'b1;
        t_left--;
        n_hi++;
        if (t_left == 0) t_guard = 2;
      end else begin
        txe_n = 1'b0;
        if (t_guard > 0) t_guard--;
      end
      if (!rnd && stalled && n_hi == 2 && !mid_done) begin
        mid_done = 1;
        check({nm, "_wr_n_in_stall"}, {63'd0, wr_n}, 64'd1);
        check({nm, "_byte_held"}, {56'd0, adbus}, {56'd0, 8'(sent >> (8 * stall_after))});
      end
      if (rnd) begin
        if (r_left == 0 && r_guard == 0 && $urandom_range(3) == 0) r_left = $urandom_range(3, 1);
        if (r_left > 0) begin
          rxf_block = 1'b1;
          r_left--;
          if (r_left == 0) r_guard = 2;
        end else begin
          rxf_block = 1'b0;
          if (r_guard > 0) r_guard--;
        end
      end
      @(negedge clk);
      if (rsp_valid) begin
        got    = 1;
        lat    = cyc - acc;
        g_data = rsp_data;
        g_err  = rsp_err;
      end
    end
    check({nm, "_rsp_seen"}, {63'd0, got}, 64'd1);
    if (got) begin
      check({nm, "_rsp_data"}, g_data, exp_data);
      check({nm, "_rsp_err"}, {63'd0, g_err}, {63'd0, exp_err});
      if (exp_lat >= 0) check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    end
    check({nm, "_addr_sent"}, dev_addr, sent);
    check({nm, "_addr_bytes"}, 64'(dev_addr_cnt), 64'd8);
    txe_n     = 1'b0;
    rxf_block = 1'b0;
    dev_clr   = 1'b1;
    @(negedge clk);
    dev_clr   = 1'b0;
  endtask

  typedef struct {
    logic [63:0] addr;
    int          stall_after;
    int          stall_len;
    bit          rxf_never;
    logic [63:0] exp_data;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[4];

  initial begin
    bit seen;
    logic [63:0] a;
    // 20 = 8 addr + 1 turn + 1 wait + 1 oe + 8 data + 1 resp.
    // 26: five txe_n-high edges plus one edge to re-lower wr_n.
    // 25: 9 edges to reach WAIT_RXF, then TO stalled edges.
    vecs[0] = '{64'h2000, -1, 0, 1'b0, 64'h1122334455667788, 1'b0, 20};
    vecs[1] = '{64'h2005, -1, 0, 1'b0, 64'h1122334455667788, 1'b0, 20};
    vecs[2] = '{64'hA1B2C3D4E5F60718, 3, 5, 1'b0, word_of(64'hA1B2C3D4E5F60718), 1'b0, 26};
    vecs[3] = '{64'h2000, -1, 0, 1'b1, 64'h0, 1'b1, 9 + TO};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; txe_n = 1'b0; rxf_block = 1'b0; dev_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready_rsp_pins", {57'd0, req_ready, rsp_valid, rsp_err, wr_n, rd_n, oe_n, siwu_n},
          {57'd0, 7'b1001111});
    check("rst_rsp_data", rsp_data, 64'd0);
    check("rst_adbus_released", {63'd0, dut.drive_q}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].stall_after, vecs[i].stall_len,
              vecs[i].rxf_never, 1'b0, vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat);

    // Reset in the middle of the data phase aborts without a response.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 64'h2000;
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (dev_rd_cnt == 4) seen = 1;
    end
    check("midrst_reached_read4", {63'd0, seen}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pins_idle", {59'd0, wr_n, rd_n, oe_n, req_ready, dut.drive_q}, {59'd0, 5'b11110});
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    check("midrst_no_rsp", {63'd0, seen}, 64'd0);
    run_txn("after_rst", 64'h2000, -1, 0, 1'b0, 1'b0, 64'h1122334455667788, 1'b0, 20);

    // Random addresses with random short txe_n/rxf_n stalls.
    for (int i = 0; i < 16; i++) begin
      a = {$urandom, $urandom};
      run_txn($sformatf("rnd%0d", i), a, -1, 0, 1'b0, 1'b1, word_of(a & ~64'h7), 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d miscompares %0d", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
